// File: rtl/ui_setting_ctrl.sv
// Front-panel settings controller: menu FSM editing display mode, gain and decay, plus a freeze toggle.
// Optional frame-timed menu exit is built when UI_MENU_TIMEOUT_EN is defined.
module ui_setting_ctrl #(
  parameter int unsigned TIMEOUT_FRAMES = 180,
  parameter int unsigned GAIN_INIT      = 3,
  parameter int unsigned GAIN_MAX       = 7,
  parameter int unsigned DECAY_INIT     = 8,
  parameter int unsigned DECAY_MAX      = 15
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       Frame,
  input  logic [3:0] Push,
  output logic [1:0] DispMode,
  output logic [2:0] Gain,
  output logic [3:0] Decay,
  output logic       Freeze,
  output logic       MenuActive,
  output logic [1:0] MenuItem,
  output logic       SettingChanged
);

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned GAIN_W  = 3;
  localparam int unsigned DECAY_W = 4;
  localparam int unsigned ITEM_W  = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_MODE  = 2'd1,
    EDIT_GAIN  = 2'd2,
    EDIT_DECAY = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   disp_q, disp_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [DECAY_W-1:0]  decay_q, decay_d;
  logic                freeze_q, freeze_d;
  logic                active_q, active_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic                changed_q, changed_d;

  logic press_mode_c;
  logic press_hold_c;
  logic in_edit_c;
  logic step_up_c;
  logic step_dn_c;
  logic timeout_c;

  // MODE masks UP/DOWN; UP and DOWN together cancel
  assign press_mode_c = Push[0];
  assign press_hold_c = Push[3];
  assign in_edit_c    = (state_q != IDLE);
  assign step_up_c    = in_edit_c & ~press_mode_c & Push[1] & ~Push[2];
  assign step_dn_c    = in_edit_c & ~press_mode_c & Push[2] & ~Push[1];

`ifdef UI_MENU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_FRAMES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reload_c;

  assign reload_c  = (~in_edit_c & press_mode_c) | (in_edit_c & (|Push[2:0]));
  assign timeout_c = in_edit_c & Frame & ~(|Push[2:0]) & (cnt_q <= CNT_W'(1));

  // Inactivity counter: any navigation/edit press reloads, frames count down
  always_comb begin
    cnt_d = cnt_q;
    if (reload_c) begin
      cnt_d = CNT_W'(TIMEOUT_FRAMES);
    end else if (in_edit_c && Frame && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_frame;

  assign unused_frame = Frame | (TIMEOUT_FRAMES == 0);
  assign timeout_c    = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: MODE steps the menu ring, timeout drops back to IDLE
  always_comb begin
    state_d = state_q;
    if (press_mode_c) begin
      case (state_q)
        IDLE:       state_d = EDIT_MODE;
        EDIT_MODE:  state_d = EDIT_GAIN;
        EDIT_GAIN:  state_d = EDIT_DECAY;
        EDIT_DECAY: state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end else if (timeout_c) begin
      state_d = IDLE;
    end
  end

  // Output/next-value logic for the registered settings and menu indicators
  always_comb begin
    disp_d   = disp_q;
    gain_d   = gain_q;
    decay_d  = decay_q;
    freeze_d = freeze_q ^ press_hold_c;
    active_d = (state_d != IDLE);
    item_d   = '0;

    case (state_q)
      EDIT_MODE: begin
        if (step_up_c) begin
          disp_d = (disp_q >= MODE_W'(2)) ? '0 : disp_q + MODE_W'(1);
        end else if (step_dn_c) begin
          disp_d = (disp_q == '0) ? MODE_W'(2) : disp_q - MODE_W'(1);
        end
      end
      EDIT_GAIN: begin
        if (step_up_c && (gain_q < GAIN_W'(GAIN_MAX))) begin
          gain_d = gain_q + GAIN_W'(1);
        end else if (step_dn_c && (gain_q != '0)) begin
          gain_d = gain_q - GAIN_W'(1);
        end
      end
      EDIT_DECAY: begin
        if (step_up_c && (decay_q < DECAY_W'(DECAY_MAX))) begin
          decay_d = decay_q + DECAY_W'(1);
        end else if (step_dn_c && (decay_q != '0)) begin
          decay_d = decay_q - DECAY_W'(1);
        end
      end
      default: ;
    endcase

    case (state_d)
      EDIT_GAIN:  item_d = ITEM_W'(1);
      EDIT_DECAY: item_d = ITEM_W'(2);
      default:    item_d = '0;
    endcase

    changed_d = (disp_d != disp_q) | (gain_d != gain_q) |
                (decay_d != decay_q) | (freeze_d != freeze_q);
  end

  // Registered outputs
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      disp_q    <= '0;
      gain_q    <= GAIN_W'(GAIN_INIT);
      decay_q   <= DECAY_W'(DECAY_INIT);
      freeze_q  <= 1'b0;
      active_q  <= 1'b0;
      item_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      gain_q    <= gain_d;
      decay_q   <= decay_d;
      freeze_q  <= freeze_d;
      active_q  <= active_d;
      item_q    <= item_d;
      changed_q <= changed_d;
    end
  end

  assign DispMode       = disp_q;
  assign Gain           = gain_q;
  assign Decay          = decay_q;
  assign Freeze         = freeze_q;
  assign MenuActive     = active_q;
  assign MenuItem       = item_q;
  assign SettingChanged = changed_q;

endmodule

// File: tb/tb_ui_setting_ctrl.sv
// Directed self-checking bench for ui_setting_ctrl; timeout steps run only with UI_MENU_TIMEOUT_EN.
module tb_ui_setting_ctrl;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_MODE = 4'b0001;
  localparam logic [3:0] P_UP   = 4'b0010;
  localparam logic [3:0] P_DN   = 4'b0100;
  localparam logic [3:0] P_HOLD = 4'b1000;

  logic       Clock;
  logic       ResetN;
  logic       Frame;
  logic [3:0] Push;
  logic [1:0] DispMode;
  logic [2:0] Gain;
  logic [3:0] Decay;
  logic       Freeze;
  logic       MenuActive;
  logic [1:0] MenuItem;
  logic       SettingChanged;

  int checks;
  int failures;

  ui_setting_ctrl #(
    .TIMEOUT_FRAMES(4),
    .GAIN_INIT(3),
    .GAIN_MAX(7),
    .DECAY_INIT(8),
    .DECAY_MAX(15)
  ) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .Frame(Frame),
    .Push(Push),
    .DispMode(DispMode),
    .Gain(Gain),
    .Decay(Decay),
    .Freeze(Freeze),
    .MenuActive(MenuActive),
    .MenuItem(MenuItem),
    .SettingChanged(SettingChanged)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
  task automatic step(input logic [3:0] p, input logic f);
    Push  = p;
    Frame = f;
    @(posedge Clock);
    #1;
    Push  = P_NONE;
    Frame = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int disp, input int gain, input int decay,
                         input int frz, input int act, input int item, input int chg);
    chk({tag, ".disp"},   32'(DispMode),       32'(disp));
    chk({tag, ".gain"},   32'(Gain),           32'(gain));
    chk({tag, ".decay"},  32'(Decay),          32'(decay));
    chk({tag, ".freeze"}, 32'(Freeze),         32'(frz));
    chk({tag, ".active"}, 32'(MenuActive),     32'(act));
    chk({tag, ".item"},   32'(MenuItem),       32'(item));
    chk({tag, ".chg"},    32'(SettingChanged), 32'(chg));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ResetN   = 1'b0;
    Push     = P_NONE;
    Frame    = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk_all("reset", 0, 3, 8, 0, 0, 0, 0);
    ResetN = 1'b1;
    step(P_NONE, 1'b0);
    chk_all("post_reset", 0, 3, 8, 0, 0, 0, 0);

    // Display mode editing with modulo-3 wrap
    step(P_MODE, 1'b0); chk_all("enter_mode", 0, 3, 8, 0, 1, 0, 0);
    step(P_UP, 1'b0);   chk_all("mode_up1",   1, 3, 8, 0, 1, 0, 1);
    step(P_UP, 1'b0);   chk_all("mode_up2",   2, 3, 8, 0, 1, 0, 1);
    step(P_UP, 1'b0);   chk_all("mode_wrap",  0, 3, 8, 0, 1, 0, 1);
    step(P_NONE, 1'b0); chk_all("mode_quiet", 0, 3, 8, 0, 1, 0, 0);
    step(P_DN, 1'b0);   chk_all("mode_dnwrap", 2, 3, 8, 0, 1, 0, 1);
    step(P_UP, 1'b0);   chk_all("mode_back0", 0, 3, 8, 0, 1, 0, 1);

    // Gain up to saturation
    step(P_MODE, 1'b0); chk_all("enter_gain", 0, 3, 8, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(P_UP, 1'b0);
      chk("gain_up.val", 32'(Gain), 32'((i < 4) ? 4 + i : 7));
      chk("gain_up.chg", 32'(SettingChanged), 32'((i < 4) ? 1 : 0));
    end
    step(P_DN, 1'b0);   chk_all("gain_dn", 0, 6, 8, 0, 1, 1, 1);

    // Decay: cancel, floor and ceiling saturation
    step(P_MODE, 1'b0);        chk_all("enter_decay", 0, 6, 8, 0, 1, 2, 0);
    step(P_UP | P_DN, 1'b0);   chk_all("decay_updn",  0, 6, 8, 0, 1, 2, 0);
    for (int i = 0; i < 9; i++) begin
      step(P_DN, 1'b0);
      chk("decay_dn.val", 32'(Decay), 32'((i < 8) ? 7 - i : 0));
      chk("decay_dn.chg", 32'(SettingChanged), 32'((i < 8) ? 1 : 0));
    end
    for (int i = 0; i < 16; i++) begin
      step(P_UP, 1'b0);
      chk("decay_up.val", 32'(Decay), 32'((i < 15) ? i + 1 : 15));
      chk("decay_up.chg", 32'(SettingChanged), 32'((i < 15) ? 1 : 0));
    end
    step(P_MODE | P_UP, 1'b0); chk_all("mode_up_exit", 0, 6, 15, 0, 0, 0, 0);
    step(P_UP, 1'b0);          chk_all("idle_up",      0, 6, 15, 0, 0, 0, 0);

    // Freeze toggling in IDLE and in EDIT_GAIN
    step(P_HOLD, 1'b0);  chk_all("hold_idle1", 0, 6, 15, 1, 0, 0, 1);
    step(P_HOLD, 1'b0);  chk_all("hold_idle2", 0, 6, 15, 0, 0, 0, 1);
    step(P_MODE, 1'b0);
    step(P_MODE, 1'b0);  chk_all("to_gain",    0, 6, 15, 0, 1, 1, 0);
    step(P_HOLD, 1'b0);  chk_all("hold_gain1", 0, 6, 15, 1, 1, 1, 1);
    step(P_HOLD, 1'b0);  chk_all("hold_gain2", 0, 6, 15, 0, 1, 1, 1);
    step(P_HOLD | P_UP, 1'b0); chk_all("hold_up",  0, 7, 15, 1, 1, 1, 1);
    step(P_DN, 1'b0);          chk_all("gain_to6", 0, 6, 15, 1, 1, 1, 1);

`ifdef UI_MENU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step(P_NONE, 1'b1);
      chk("to_gain_wait.active", 32'(MenuActive), 32'(1));
    end
    step(P_NONE, 1'b1);  chk_all("to_gain_exit", 0, 6, 15, 1, 0, 0, 0);
    step(P_MODE, 1'b0);  chk_all("to_enter",     0, 6, 15, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(P_NONE, 1'b1);
      chk("to_mode_wait.active", 32'(MenuActive), 32'(1));
    end
    step(P_NONE, 1'b1);  chk_all("to_mode_exit", 0, 6, 15, 1, 0, 0, 0);
    step(P_MODE, 1'b0);
    step(P_NONE, 1'b1);
    step(P_NONE, 1'b1);
    step(P_UP, 1'b1);    chk_all("to_reload",    1, 6, 15, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(P_NONE, 1'b1);
      chk("to_reload_wait.active", 32'(MenuActive), 32'(1));
    end
    step(P_NONE, 1'b1);  chk_all("to_reload_exit", 1, 6, 15, 1, 0, 0, 0);
`else
    for (int i = 0; i < 6; i++) begin
      step(P_NONE, 1'b1);
      chk("no_to.active", 32'(MenuActive), 32'(1));
    end
    step(P_MODE, 1'b0);
    step(P_MODE, 1'b0);  chk_all("no_to_exit", 0, 6, 15, 1, 0, 0, 0);
`endif

    // Asynchronous reset mid EDIT_GAIN with Gain=6, Freeze=1
    step(P_MODE, 1'b0);
    step(P_MODE, 1'b0);
    chk("pre_rst.gain",   32'(Gain),       32'(6));
    chk("pre_rst.freeze", 32'(Freeze),     32'(1));
    chk("pre_rst.item",   32'(MenuItem),   32'(1));
    chk("pre_rst.active", 32'(MenuActive), 32'(1));
    #2;
    ResetN = 1'b0;
    #1;
    chk_all("async_rst", 0, 3, 8, 0, 0, 0, 0);
    @(posedge Clock);
    #1;
    ResetN = 1'b1;
    step(P_NONE, 1'b0);  chk_all("after_rst", 0, 3, 8, 0, 0, 0, 0);
    step(P_MODE, 1'b0);  chk_all("rst_reenter", 0, 3, 8, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
